// File: rtl/cdc_byte_packer.sv
// cdc_byte_packer: packs CDC samples into LANES-wide words behind a FWFT queue
// Ports:
//   clk_b, rst                  clock, synchronous active-high reset
//   data_valid_b, data_b        sample strobe and sample (no backpressure)
//   word_valid, word_ready      output handshake (pop when both high)
//   word_data, word_keep        head word (lane 0 in LSBs) and lane mask
//   lvl                         queue occupancy
//   overflow, overflow_clr      sticky word-drop flag and its clear
module cdc_byte_packer #(
    parameter int WIDTH         = 8,
    parameter int LANES         = 4,
    parameter int OUT_DEPTH     = 4,
    parameter int FLUSH_TIMEOUT = 64
) (
    input  logic                           clk_b,
    input  logic                           rst,
    input  logic                           data_valid_b,
    input  logic [WIDTH-1:0]               data_b,
    output logic                           word_valid,
    input  logic                           word_ready,
    output logic [WIDTH*LANES-1:0]         word_data,
    output logic [LANES-1:0]               word_keep,
    output logic [$clog2(OUT_DEPTH+1)-1:0] lvl,
    output logic                           overflow,
    input  logic                           overflow_clr
);
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IW = $clog2(FLUSH_TIMEOUT);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int LW = $clog2(OUT_DEPTH+1);
    localparam int DW = WIDTH*LANES;

    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idle;
    logic [DW-1:0]    r_pack;
    logic [DW-1:0]    r_mem [OUT_DEPTH];
    logic [LANES-1:0] r_kmem [OUT_DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [LW-1:0]    r_lvl;
    logic             r_ovf;

    logic             w_full;
    logic             w_flush;
    logic             w_commit;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [DW-1:0]    w_word;
    logic [LANES-1:0] w_mask;
    logic [LANES-1:0] w_keep;

    // Lanes below the current count hold real samples in a partial word.
    for (genvar g = 0; g < LANES; g++) begin : g_mask
        assign w_mask[g] = r_cnt > CW'(g);
    end

    assign w_full   = data_valid_b && (r_cnt == CW'(LANES-1));
    // A sample in the expiry cycle takes priority, so flush requires no sample.
    assign w_flush  = !data_valid_b && (r_cnt != '0) && (r_idle == IW'(FLUSH_TIMEOUT-1));
    assign w_commit = w_full || w_flush;
    // The full word includes the sample arriving this cycle in the top lane.
    assign w_word   = w_full ? {data_b, r_pack[DW-WIDTH-1:0]} : r_pack;
    assign w_keep   = w_full ? '1 : w_mask;

    assign word_valid = r_lvl != '0;
    assign w_pop      = word_valid && word_ready;
    // When full, a same-cycle pop frees the slot the write pointer now names.
    assign w_push     = w_commit && ((r_lvl != LW'(OUT_DEPTH)) || w_pop);
    assign w_drop     = w_commit && !w_push;

    assign word_data = word_valid ? r_mem[r_rptr]  : '0;
    assign word_keep = word_valid ? r_kmem[r_rptr] : '0;
    assign lvl       = r_lvl;
    assign overflow  = r_ovf;

    always_ff @(posedge clk_b) begin
        if (rst) begin
            r_cnt  <= '0;
            r_pack <= '0;
        end else if (w_commit) begin
            r_cnt  <= '0;
            r_pack <= '0;
        end else if (data_valid_b) begin
            r_pack[r_cnt*WIDTH +: WIDTH] <= data_b;
            r_cnt                        <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_b) begin
        if (rst || data_valid_b || w_commit || r_cnt == '0)
            r_idle <= '0;
        else
            r_idle <= r_idle + 1'b1;
    end

    always_ff @(posedge clk_b) begin
        if (w_push) begin
            r_mem[r_wptr]  <= w_word;
            r_kmem[r_wptr] <= w_keep;
        end
    end

    always_ff @(posedge clk_b) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_lvl  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_wptr <= w_push ? r_wptr + 1'b1 : r_wptr;
            r_rptr <= w_pop  ? r_rptr + 1'b1 : r_rptr;
            r_lvl  <= r_lvl + LW'(w_push) - LW'(w_pop);
            r_ovf  <= w_drop ? 1'b1 : (overflow_clr ? 1'b0 : r_ovf);
        end
    end
endmodule

// File: doc/cdc_byte_packer.md
# cdc_byte_packer

Packs the narrow sample stream leaving the CDC FIFO into LANES-wide words and queues them for the downstream consumer. It sits in the clk_b domain, directly after the CDC stage, and takes that stage's data_valid_b/data_b outputs as is. That input has no backpressure, so this block buffers completed words in a small first-word-fall-through (FWFT) queue. Words that cannot be stored are dropped and flagged. Partial words are flushed after an idle timeout.

## Interface
Parameters:
- WIDTH, default 8: sample width in bits; must match the CDC stage.
- LANES, default 4: samples per output word.
- OUT_DEPTH, default 4: output queue depth in words; must be a power of 2 and at least 2.
- FLUSH_TIMEOUT, default 64: consecutive idle cycles before a partial word is flushed; at least 2.

Ports (clock and reset first):
- clk_b  in  1: single clock, 125 MHz.
- rst  in  1: reset, synchronous, active-high.
- data_valid_b  in  1: input sample strobe, one sample per cycle.
- data_b  in  WIDTH: input sample.
- word_valid  out  1: output word available.
- word_ready  in  1: consumer accepts the word.
- word_data  out  WIDTH*LANES: output word; lane 0 is in the LSBs.
- word_keep  out  LANES: lane-valid mask.
- lvl  out  $clog2(OUT_DEPTH+1): queue occupancy.
- overflow  out  1: sticky word-drop flag.
- overflow_clr  in  1: clears overflow.

## Operation
- **Lane packing.** Lane counter cnt runs 0..LANES-1. An accepted sample is written into lane cnt, and cnt increments. The first sample of a word goes to lane 0.
- **Full-word commit.** When the sample lands in lane LANES-1, the assembled word (including that sample) is committed with keep all ones. cnt and the pack register clear at the same edge.
- **Idle counter.** It increments on each cycle where data_valid_b=0 and cnt>0. It clears on any sample, on any commit, and when cnt=0.
- **Timeout flush.** When the idle counter equals FLUSH_TIMEOUT-1 and data_valid_b=0, the partial word is committed. Its keep has bits 0..cnt-1 set, and unfilled lanes are zero. cnt clears.
- **Sample wins over flush.** A sample arriving in the expiry cycle cancels the flush and is packed normally.
- **Queue.** FWFT, OUT_DEPTH entries. word_valid = (lvl != 0). A pop occurs when word_valid and word_ready are both 1.
- **Stable output.** word_data and word_keep stay stable while word_valid=1 and word_ready=0.
- **Drop on full.** A commit while lvl=OUT_DEPTH with no pop in the same cycle drops the word and sets overflow. Packing continues unaffected.
- **Commit and pop together.** If a commit and a pop occur in the same cycle, both happen; lvl is unchanged and nothing is dropped.
- **Overflow clear.** overflow_clr=1 clears overflow at the next edge. A drop in the same cycle wins, so overflow stays 1.
- **Queue pointers.** Read and write pointers wrap modulo OUT_DEPTH. lvl is a separate counter, not derived from the pointers.

## Timing
- **Reset values**, applied at the clk_b edge where rst=1: word_valid=0, word_data=0, word_keep=0, lvl=0, overflow=0.
- **Reset internals:** cnt=0, idle counter=0, pack register=0, queue pointers=0.
- **Reset mid-operation:** the partial word and all queued words are discarded. Samples presented while rst=1 are ignored.
- **Full-word latency:** if the last lane's sample is sampled at edge t and the queue is empty, word_valid=1 in the cycle after t (1 cycle).
- **Flush latency:** if the last sample is at edge t and no sample follows, the flush commits at edge t+FLUSH_TIMEOUT. word_valid then rises in the following cycle.
- **lvl timing:** lvl updates at the same edge as the commit or pop.
- **Throughput:** one sample per cycle sustained. The output side is capable of one word per cycle.

## Test plan
- **Back-to-back packing.** Apply samples 0x01..0x08 back-to-back with word_ready=1. Require word 0x04030201 with keep 0xF, with word_valid one cycle after the 0x04 edge. Then require 0x08070605 with keep 0xF. overflow stays 0.
- **Timeout flush.** Apply 0xA1, 0xA2, 0xA3 and then idle. Require word 0x00A3A2A1 with keep 0x7, and word_valid rising in the cycle after edge t+64, where t is the 0xA3 edge.
- **Flush cancelled by late sample.** Repeat the previous scenario, but present 0xA4 at edge t+64. Require no flush and word 0xA4A3A2A1 with keep 0xF.
- **Overflow and recovery.** Hold word_ready=0 and apply 24 samples. Require lvl=4, words 5 and 6 dropped, and overflow=1. Then set word_ready=1. Require exactly the first 4 words, in order, and lvl back to 0.
- **Simultaneous commit and pop when full.** With lvl=4, align a pop with the cycle the next word commits. Require lvl to stay 4 and overflow to stay 0.
- **Reset and overflow-clear precedence.** Pulse rst with 2 samples pending and 2 words queued. Require word_valid=0 and lvl=0 after the edge. The next 4 samples must form a fresh word with keep 0xF. Separately, assert overflow_clr in the same cycle as a drop; overflow must stay 1.
